// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - 2-way set-associative write-back, write-allocate cache with per-set LRU
module assoc_cache #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int WORDS  = 16,
    parameter int SETS   = 256,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [WORD_W-1:0]       cpu_wdata,
    output logic [WORD_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic                    cpu_busy,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORDS*WORD_W-1:0] mem_wdata,
    input  logic [WORDS*WORD_W-1:0] mem_rdata,
    input  logic                    mem_ack,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef logic [WORDS-1:0][WORD_W-1:0] block_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, WBACK, FILL} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                replay;
    logic                victim_q;
    logic [WORD_W-1:0]   rdata_q;

    logic [1:0]          valid [SETS];
    logic [1:0]          dirty [SETS];
    logic [SETS-1:0]     lru;
    logic [TAG_W-1:0]    tag_mem  [2][SETS];
    block_t              data_mem [2][SETS];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [OFF_W-1:0]    off;
    logic [1:0]          way_hit;
    logic                hit;
    logic                hit_way;
    logic                victim;
    logic [WORD_W-1:0]   hit_word;
    logic [ADDR_W-1:0]   fill_addr;

    assign idx       = addr_q[OFF_W +: IDX_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign off       = addr_q[OFF_W-1:0];
    assign fill_addr = {tag, idx, {OFF_W{1'b0}}};

    always_comb begin
        way_hit = 2'b00;
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = valid[idx][w] && (tag_mem[w][idx] == tag);
        end
        hit     = |way_hit;
        hit_way = way_hit[1];
        if (!valid[idx][0])      victim = 1'b0;
        else if (!valid[idx][1]) victim = 1'b1;
        else                     victim = lru[idx];
        hit_word = data_mem[hit_way][idx][off];
    end

    // Completion is reported in the LOOKUP cycle itself so a hit finishes one cycle after acceptance.
    assign cpu_ready = (state == LOOKUP) && hit;
    assign cpu_rdata = (cpu_ready && !we_q) ? hit_word : rdata_q;
    assign cpu_busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (state == FILL && mem_req && mem_ack) begin
            tag_mem[victim_q][idx]  <= tag;
            data_mem[victim_q][idx] <= mem_rdata;
        end else if (cpu_ready && we_q) begin
            data_mem[hit_way][idx][off] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            replay    <= 1'b0;
            victim_q  <= 1'b0;
            rdata_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            lru       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= 2'b00;
                dirty[s] <= 2'b00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        replay  <= 1'b0;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        state    <= IDLE;
                        lru[idx] <= ~hit_way;
                        if (we_q) dirty[idx][hit_way] <= 1'b1;
                        else      rdata_q <= hit_word;
                        // The replay after a fill is the original access, not a new hit.
                        if (!replay && !(&hit_cnt)) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else begin
                        if (!replay && !(&miss_cnt)) miss_cnt <= miss_cnt + CNT_W'(1);
                        victim_q <= victim;
                        mem_req  <= 1'b1;
                        if (valid[idx][victim] && dirty[idx][victim]) begin
                            state     <= WBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_mem[victim][idx], idx, {OFF_W{1'b0}}};
                            mem_wdata <= data_mem[victim][idx];
                        end else begin
                            state    <= FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= fill_addr;
                        end
                    end
                end
                WBACK: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= fill_addr;
                    end else if (mem_ack) begin
                        mem_req              <= 1'b0;
                        valid[idx][victim_q] <= 1'b1;
                        dirty[idx][victim_q] <= 1'b0;
                        replay               <= 1'b1;
                        state                <= LOOKUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_cache.sv
// tb/tb_assoc_cache.sv - directed and randomized checks of assoc_cache against a behavioural model
module tb_assoc_cache;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [31:0]   cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic          cpu_busy;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [511:0]  mem_wdata;
    logic [511:0]  mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    assoc_cache #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // golden: value the CPU must observe; memw: what backing memory holds
    logic [31:0] golden [logic [31:0]];
    logic [31:0] memw   [logic [31:0]];
    logic        m_valid [256][2];
    logic        m_dirty [256][2];
    logic [19:0] m_tag   [256][2];
    int          m_ts    [256][2];
    int          now_ts;
    int          exp_hits;
    int          exp_miss;
    logic [31:0] last_rd;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] gold(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_word(a);
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return memw.exists(a) ? memw[a] : init_word(a);
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 256; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_ts[s][w]    = 0;
            end
        end
        exp_hits = 0;
        exp_miss = 0;
        last_rd  = '0;
        golden.delete();
        foreach (memw[k]) golden[k] = memw[k];
    endtask

    task automatic serve(input logic exp_we, input logic [31:0] a, input string nm);
        int n = 0;
        logic [511:0] blk;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_req"}, mem_req, 1'b1);
        if (mem_req !== 1'b1) return;
        chk({nm, "_we"}, mem_we, exp_we);
        chk({nm, "_addr"}, mem_addr, a);
        for (int i = 0; i < 16; i++) blk[i*32 +: 32] = exp_we ? gold(a + i) : memrd(a + i);
        if (exp_we) begin
            chk({nm, "_data"}, mem_wdata, blk);
            for (int i = 0; i < 16; i++) memw[a + i] = gold(a + i);
        end else begin
            mem_rdata = blk;
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk({nm, "_hold"}, {mem_req, mem_addr}, {1'b1, a});
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 16; i++) mem_rdata[i*32 +: 32] = $urandom;
        chk({nm, "_drop"}, mem_req, 1'b0);
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [7:0]  s = a[11:4];
        logic [19:0] t = a[31:12];
        int hw = -1;
        int v = 0;
        int n = 0;
        logic wb = 1'b0;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (hw < 0) begin
            if (!m_valid[s][0])      v = 0;
            else if (!m_valid[s][1]) v = 1;
            else                     v = (m_ts[s][0] < m_ts[s][1]) ? 0 : 1;
            wb = m_valid[s][v] && m_dirty[s][v];
        end
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1;
        // keep requesting junk while busy; it must be ignored
        cpu_we = ~we; cpu_addr = $urandom; cpu_wdata = $urandom;
        @(negedge clk);
        chk("busy", cpu_busy, 1'b1);
        chk("hit_now", cpu_ready, (hw >= 0));
        if (hw >= 0) begin
            chk("no_mem", mem_req, 1'b0);
        end else begin
            if (wb) serve(1'b1, {m_tag[s][v], s, 4'h0}, "wback");
            serve(1'b0, {t, s, 4'h0}, "fill");
            chk("replay_ready", cpu_ready, 1'b1);
        end
        while (cpu_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready", cpu_ready, 1'b1);
        if (!we) chk("rdata", cpu_rdata, gold(a));
        cpu_req = 1'b0;
        if (hw < 0) begin
            hw = v;
            m_valid[s][hw] = 1'b1;
            m_dirty[s][hw] = 1'b0;
            m_tag[s][hw]   = t;
            exp_miss = sat(exp_miss + 1);
        end else begin
            exp_hits = sat(exp_hits + 1);
        end
        now_ts++;
        m_ts[s][hw] = now_ts;
        if (we) begin
            m_dirty[s][hw] = 1'b1;
            golden[a] = wd;
        end else begin
            last_rd = gold(a);
        end
        @(negedge clk);
        chk("idle", {cpu_busy, cpu_ready}, 2'b00);
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_miss);
        chk("rdata_hold", cpu_rdata, last_rd);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        model_reset();
        now_ts = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", {cpu_busy, cpu_ready, mem_req, mem_we}, 4'b0000);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ack_in_idle", mem_req, 1'b0);

        access(1'b0, 32'h0000_1234, '0);
        access(1'b0, 32'h0000_1234, '0);
        access(1'b1, 32'h0000_1234, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_2234, '0);
        access(1'b0, 32'h0000_3234, '0);
        access(1'b0, 32'h0000_1234, '0);

        access(1'b0, 32'h0001_0230, '0);
        access(1'b0, 32'h0001_1230, '0);
        access(1'b0, 32'h0001_0230, '0);
        access(1'b0, 32'h0001_2230, '0);
        access(1'b0, 32'h0001_0230, '0);
        access(1'b0, 32'h0001_1230, '0);

        // abandon a fill with reset, then a stray ack
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hABCD_E770;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mid_fill_req", {mem_req, mem_we}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem", {mem_req, mem_we, cpu_busy, cpu_ready}, 4'b0000);
        chk("mid_rst_cnts", {hit_cnt, miss_cnt}, 4'b0000);
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack", {mem_req, cpu_busy}, 2'b00);
        end

        access(1'b0, 32'h0000_1234, '0);
        access(1'b0, 32'h0001_0230, '0);
        for (int i = 0; i < 5; i++) access(1'b0, 32'h0000_1230 + i, '0);
        chk("hit_sat", hit_cnt, 2'd3);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = {12'h0, 4'($urandom_range(0, 3)), 8'h23 + 8'($urandom_range(0, 2)), 4'($urandom)};
            access(1'($urandom), a, $urandom);
        end
        chk("miss_sat", miss_cnt, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 32, word-address width.
REQ-002 Parameter WORD_W, default 32, data word width.
REQ-003 Parameter WORDS, default 16, words per block (power of 2); OFF_W = log2(WORDS).
REQ-004 Parameter SETS, default 256, sets per way (power of 2); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.
REQ-005 Parameter CNT_W, default 16, width of the performance counters.
REQ-006 Ports; one clock, reset asynchronous active-low:
  clk        in   1                 clock, all state on rising edge
  rst_n      in   1                 asynchronous active-low reset
  cpu_req    in   1                 CPU request strobe
  cpu_we     in   1                 1 = write word, 0 = read word
  cpu_addr   in   ADDR_W            word address {tag, index, offset}
  cpu_wdata  in   WORD_W            write data
  cpu_rdata  out  WORD_W            read data, valid when cpu_ready=1
  cpu_ready  out  1                 one-cycle completion pulse
  cpu_busy   out  1                 1 whenever state != IDLE
  mem_req    out  1                 memory block request
  mem_we     out  1                 1 = block write-back, 0 = block fill
  mem_addr   out  ADDR_W            block address, offset bits zero
  mem_wdata  out  WORDS*WORD_W      evicted block, word 0 in LSBs
  mem_rdata  in   WORDS*WORD_W      fill block, word 0 in LSBs
  mem_ack    in   1                 memory completion, one-cycle pulse
  hit_cnt    out  CNT_W             saturating hit counter
  miss_cnt   out  CNT_W             saturating miss counter

Function
REQ-007 Organisation: 2-way set-associative; per way and set: valid, dirty, tag, block; per set: one LRU bit (names the least-recently-used way); write-back, write-allocate.
REQ-008 FSM states: IDLE, LOOKUP, WBACK, FILL.
REQ-009 IDLE: cpu_req=1 latches cpu_addr/cpu_we/cpu_wdata and goes to LOOKUP; cpu_req outside IDLE is ignored.
REQ-010 LOOKUP hit (valid and tag match in either way): cpu_ready=1 for that cycle; read -> cpu_rdata = addressed word; write -> word updated, dirty=1; LRU set to the other way; hit_cnt increments; go to IDLE. Hit latency: ready exactly one cycle after acceptance.
REQ-011 LOOKUP miss: miss_cnt increments; victim = first invalid way (way 0 before way 1), else the LRU way; victim valid and dirty -> WBACK, else -> FILL.
REQ-012 WBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim block, held stable until mem_ack; on mem_ack -> FILL.
REQ-013 FILL: mem_req=1, mem_we=0, mem_addr={request tag, index, 0}; on mem_ack the victim is written with mem_rdata, tag, valid=1, dirty=0, then -> LOOKUP; the replay hits and is not counted as a second miss.
REQ-014 mem_req deasserts in the cycle after mem_ack is sampled; mem_ack in IDLE or LOOKUP is ignored.
REQ-015 Counters saturate at all-ones and never wrap.
REQ-016 cpu_rdata holds its last value when cpu_ready=0.

Reset
REQ-017 rst_n=0 asynchronously forces: state IDLE, all valid, dirty and LRU bits 0, cpu_ready=0, mem_req=0, mem_we=0, cpu_rdata=0, hit_cnt=0, miss_cnt=0; tag and data arrays are not reset.
REQ-018 Reset during WBACK or FILL abandons the transaction; mem_req falls with rst_n, and a later mem_ack is ignored.

Verification
REQ-019 Cold read 0x0000_1234 -> miss_cnt=1; FILL with mem_addr=0x0000_1230; after mem_ack, cpu_ready with word 4 of mem_rdata.
REQ-020 Repeat read 0x0000_1234 -> cpu_ready one cycle after accept, no mem_req, hit_cnt=1.
REQ-021 Write 0xDEADBEEF to 0x0000_1234, then read 0x0000_2234 and 0x0000_3234 (same set) -> second miss evicts the dirty way: WBACK with mem_addr=0x0000_1230 and word 4 = 0xDEADBEEF, then FILL 0x0000_3230.
REQ-022 LRU check: fill both ways of set 0x23, touch way 0, miss on a third tag -> way 1 is replaced.
REQ-023 Assert rst_n=0 mid-FILL, release, pulse mem_ack -> mem_req=0, state IDLE, every access misses again.
REQ-024 CNT_W=2, five hits -> hit_cnt saturates at 3.
